// File: rtl/pc_unit.sv
// Program counter with next-PC select and a circular return-address stack; pc is registered and updates one edge after op.
// No backpressure beyond stall, which freezes all state (pc_next then equals pc).
module pc_unit #(
  parameter int               WIDTH     = 32,
  parameter int               INC       = 4,
  parameter int               RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [31:0]      TRAP_VEC  = 32'h0000_0080
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic [2:0]                   op,
  input  logic [WIDTH-1:0]             offset,
  input  logic [WIDTH-1:0]             target,
  output logic [WIDTH-1:0]             pc,
  output logic [WIDTH-1:0]             pc_next,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_empty,
  output logic                         ras_full,
  output logic                         ras_ovf,
  output logic                         ras_unf
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    OP_SEQ    = 3'd0,
    OP_BRANCH = 3'd1,
    OP_JUMP   = 3'd2,
    OP_CALL   = 3'd3,
    OP_RET    = 3'd4,
    OP_TRAP   = 3'd5
  } op_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]    wp_q, wp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push;
  logic [WIDTH-1:0] seq;
  logic [WIDTH-1:0] top;
  logic             full, empty;

  assign seq   = pc_q + WIDTH'(INC);
  // Depth is a power of two, so pointer arithmetic wraps naturally.
  assign top   = ras_q[wp_q - PW'(1)];
  assign full  = (cnt_q == CW'(RAS_DEPTH));
  assign empty = (cnt_q == '0);

  always_comb begin
    pc_d  = pc_q;
    wp_d  = wp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    if (!stall) begin
      pc_d = seq;
      case (op)
        OP_BRANCH: pc_d = pc_q + offset;
        OP_JUMP:   pc_d = target;
        OP_CALL: begin
          pc_d = target;
          push = 1'b1;
          wp_d = wp_q + PW'(1);
          // A full stack drops its oldest entry; the count saturates.
          if (full) ovf_d = 1'b1;
          else      cnt_d = cnt_q + CW'(1);
        end
        OP_RET: begin
          if (!empty) begin
            pc_d  = top;
            wp_d  = wp_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
          end else begin
            unf_d = 1'b1;
          end
        end
        OP_TRAP: pc_d = WIDTH'(TRAP_VEC);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_VEC;
      wp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Storage carries no reset; entries are only read when counted valid.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      ras_q[wp_q] <= seq;
    end
  end

  assign pc        = pc_q;
  assign pc_next   = pc_d;
  assign ras_count = cnt_q;
  assign ras_empty = empty;
  assign ras_full  = full;
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: queue-based reference model checked every cycle plus literal spot checks.
module tb_pc_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] offset = '0;
  logic [31:0] target = '0;
  logic [31:0] pc, pc_next;
  logic [2:0]  ras_count;
  logic        ras_empty, ras_full, ras_ovf, ras_unf;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  pc_unit #(
    .WIDTH(32), .INC(4), .RAS_DEPTH(DEPTH), .RESET_VEC(32'h0), .TRAP_VEC(32'h80)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .op(op), .offset(offset), .target(target),
    .pc(pc), .pc_next(pc_next), .ras_count(ras_count), .ras_empty(ras_empty),
    .ras_full(ras_full), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  // Reference model: a bounded queue of return addresses, newest at the back.
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  bit          m_ovf, m_unf;

  function automatic logic [31:0] exp_next();
    if (stall) return m_pc;
    case (op)
      3'd1: return m_pc + offset;
      3'd2: return target;
      3'd3: return target;
      3'd4: return (m_ras.size() > 0) ? m_ras[$] : m_pc + 32'd4;
      3'd5: return 32'h80;
      default: return m_pc + 32'd4;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [31:0] nxt;
    if (rst) begin
      m_pc = 32'h0;
      m_ras.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (!stall) begin
      nxt = exp_next();
      if (op == 3'd3) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
      end else if (op == 3'd4) begin
        if (m_ras.size() > 0) void'(m_ras.pop_back());
        else m_unf = 1'b1;
      end
      m_pc = nxt;
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("pc", pc, m_pc);
      cmp("pc_next", pc_next, exp_next());
      cmp("ras_count", 32'(ras_count), 32'(m_ras.size()));
      cmp("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
      cmp("ras_full", 32'(ras_full), 32'(m_ras.size() == DEPTH));
      cmp("ras_ovf", 32'(ras_ovf), 32'(m_ovf));
      cmp("ras_unf", 32'(ras_unf), 32'(m_unf));
    end
  end

  task automatic step(input logic [2:0] o, input logic [31:0] off, input logic [31:0] tgt,
                      input bit s, input bit r);
    op = o; offset = off; target = tgt; stall = s; rst = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] ret_exp [4];
    ret_exp[0] = 32'h4004; ret_exp[1] = 32'h3004; ret_exp[2] = 32'h2004; ret_exp[3] = 32'h1004;

    // Reset for two edges, then sequential fetch.
    step(3'd0, 0, 0, 0, 1);
    chk_en = 1'b1;
    step(3'd0, 0, 0, 0, 1);
    cmp("rst_pc", pc, 32'h0);
    cmp("rst_count", 32'(ras_count), 32'd0);
    cmp("rst_empty", 32'(ras_empty), 32'd1);
    step(3'd0, 0, 0, 0, 0); cmp("seq1", pc, 32'h4);
    step(3'd0, 0, 0, 0, 0); cmp("seq2", pc, 32'h8);
    step(3'd0, 0, 0, 0, 0); cmp("seq3", pc, 32'hC);
    cmp("seq_empty", 32'(ras_empty), 32'd1);

    // Negative branch and address wrap.
    step(3'd2, 0, 32'h100, 0, 0);
    step(3'd1, 32'hFFFF_FFF0, 0, 0, 0); cmp("branch_neg", pc, 32'hF0);
    step(3'd2, 0, 32'hFFFF_FFFC, 0, 0);
    step(3'd0, 0, 0, 0, 0); cmp("seq_wrap", pc, 32'h0);

    // Nested calls, including CALL immediately followed by RET.
    step(3'd2, 0, 32'h10, 0, 0);
    step(3'd3, 0, 32'h400, 0, 0); cmp("call1_pc", pc, 32'h400); cmp("call1_cnt", 32'(ras_count), 1);
    step(3'd0, 0, 0, 0, 0);       cmp("seq_pc", pc, 32'h404);   cmp("seq_cnt", 32'(ras_count), 1);
    step(3'd3, 0, 32'h800, 0, 0); cmp("call2_pc", pc, 32'h800); cmp("call2_cnt", 32'(ras_count), 2);
    step(3'd4, 0, 0, 0, 0);       cmp("ret1_pc", pc, 32'h408);  cmp("ret1_cnt", 32'(ras_count), 1);
    step(3'd4, 0, 0, 0, 0);       cmp("ret2_pc", pc, 32'h14);   cmp("ret2_cnt", 32'(ras_count), 0);

    // Overflow: five calls into a four-deep stack drop the oldest return address.
    step(3'd2, 0, 32'h0, 0, 0);
    for (int k = 1; k <= 5; k++) step(3'd3, 0, 32'h1000 * k, 0, 0);
    cmp("ovf_pc", pc, 32'h5000);
    cmp("ovf_full", 32'(ras_full), 1);
    cmp("ovf_flag", 32'(ras_ovf), 1);
    for (int k = 0; k < 4; k++) begin
      step(3'd4, 0, 0, 0, 0);
      cmp($sformatf("ovf_ret%0d", k), pc, ret_exp[k]);
    end
    step(3'd4, 0, 0, 0, 0);
    cmp("unf_pc", pc, 32'h1008);
    cmp("unf_flag", 32'(ras_unf), 1);

    // Stall holds everything; releasing it applies the held op.
    step(3'd3, 0, 32'h600, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(3'd2, 0, 32'h700, 1, 0);
      cmp("stall_pc", pc, 32'h600);
      cmp("stall_cnt", 32'(ras_count), 1);
    end
    step(3'd2, 0, 32'h700, 0, 0); cmp("unstall_pc", pc, 32'h700);

    // Trap leaves the stack alone; reset beats a concurrent CALL.
    step(3'd5, 0, 0, 0, 0);       cmp("trap_pc", pc, 32'h80); cmp("trap_cnt", 32'(ras_count), 1);
    step(3'd3, 0, 32'h900, 0, 1);
    cmp("rst2_pc", pc, 32'h0);
    cmp("rst2_cnt", 32'(ras_count), 0);
    cmp("rst2_ovf", 32'(ras_ovf), 0);
    cmp("rst2_unf", 32'(ras_unf), 0);
    step(3'd4, 0, 0, 0, 0);       cmp("post_rst_ret_pc", pc, 32'h4); cmp("post_rst_unf", 32'(ras_unf), 1);

    // Reserved op codes act as sequential.
    step(3'd6, 0, 32'h900, 0, 0); cmp("op6_pc", pc, 32'h8);
    step(3'd7, 0, 32'h900, 0, 0); cmp("op7_pc", pc, 32'hC);

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
